fp32_mul_post: RTL and testbench

- Wraps the 5-stage 24x24 pipelined mantissa array multiplier to form a complete IEEE-754 single-precision multiplier for the convolution datapath.
- Unpacks operands, drives the multiplier's mantissa inputs, and carries sign, exponent and special-case flags through a delay line matched to the multiplier latency.
- Normalizes and rounds the 48-bit product (round-to-nearest-even, RNE) and packs the FP32 result.
- All state advances only on the shared enable, which also drives the multiplier's start.

---
 rtl/fp32_mul_post.sv | 188 ++++++++++++++++++
 tb/tb_fp32_mul_post.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/fp32_mul_post.sv
// fp32_mul_post: FP32 multiplier wrapper around an external 24x24 pipelined
// mantissa multiplier. It unpacks the operands, carries sign, exponent and
// class flags alongside the multiplier, then normalizes, rounds (RNE) and
// packs the result. Every register advances only on en.
module fp32_mul_post #(
    parameter int MULT_LAT = 5,
    parameter int EXP_BIAS = 127
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        in_valid,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [23:0] man_a,
    output logic [23:0] man_b,
    input  logic [47:0] prod,
    output logic        out_valid,
    output logic [31:0] result,
    output logic        overflow,
    output logic        underflow,
    output logic        invalid
);

    // Side-band data that travels next to the mantissa multiplier.
    typedef struct packed {
        logic       vld;
        logic       sgn;
        logic [9:0] exp_sum;   // two's complement, biased exponent of the product
        logic       nan;
        logic       inf;
        logic       zero;
    } side_t;

    localparam logic [9:0] BIAS = 10'(EXP_BIAS);

    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic        zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
    logic        cls_nan, cls_inf, cls_zero;
    side_t       side_d;
    side_t       side_q [MULT_LAT];

    assign ea    = a[30:23];
    assign eb    = b[30:23];
    assign fa    = a[22:0];
    assign fb    = b[22:0];
    // Hidden bit is set for any nonzero exponent; denormals become class zero
    // below, so their mantissa product is never used.
    assign man_a = {|ea, fa};
    assign man_b = {|eb, fb};

    // Classify operands and build the side-band entry for this cycle.
    always_comb begin
        zero_a   = (ea == 8'h00);
        zero_b   = (eb == 8'h00);
        inf_a    = (ea == 8'hFF) && (fa == 23'd0);
        inf_b    = (eb == 8'hFF) && (fb == 23'd0);
        nan_a    = (ea == 8'hFF) && (fa != 23'd0);
        nan_b    = (eb == 8'hFF) && (fb != 23'd0);
        cls_nan  = nan_a | nan_b | (inf_a & zero_b) | (inf_b & zero_a);
        cls_inf  = (inf_a | inf_b) & ~cls_nan;
        cls_zero = (zero_a | zero_b) & ~cls_nan & ~cls_inf;
        side_d.vld     = in_valid;
        side_d.sgn     = a[31] ^ b[31];
        side_d.exp_sum = {2'b00, ea} + {2'b00, eb} - BIAS;
        side_d.nan     = cls_nan;
        side_d.inf     = cls_inf;
        side_d.zero    = cls_zero;
    end

    // Side delay line; the last entry lines up with prod.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MULT_LAT; i++) side_q[i] <= '0;
        end else if (en) begin
            side_q[0] <= side_d;
            for (int i = 1; i < MULT_LAT; i++) side_q[i] <= side_q[i-1];
        end
    end

    // ---------------- N1: normalize ----------------
    side_t       s_al;
    logic [23:0] nrm_mant;
    logic        nrm_g, nrm_s;
    logic [9:0]  nrm_exp;

    assign s_al = side_q[MULT_LAT-1];

    // Product of two [1,2) mantissas lies in [1,4); shift by one if bit 47 is set.
    always_comb begin
        if (prod[47]) begin
            nrm_mant = prod[47:24];
            nrm_g    = prod[23];
            nrm_s    = |prod[22:0];
            nrm_exp  = s_al.exp_sum + 10'd1;
        end else begin
            nrm_mant = prod[46:23];
            nrm_g    = prod[22];
            nrm_s    = |prod[21:0];
            nrm_exp  = s_al.exp_sum;
        end
    end

    logic        n1_vld, n1_sgn, n1_nan, n1_inf, n1_zero, n1_g, n1_s;
    logic [23:0] n1_mant;
    logic [9:0]  n1_exp;

    // N1 register stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n1_vld  <= 1'b0;
            n1_sgn  <= 1'b0;
            n1_nan  <= 1'b0;
            n1_inf  <= 1'b0;
            n1_zero <= 1'b0;
            n1_g    <= 1'b0;
            n1_s    <= 1'b0;
            n1_mant <= '0;
            n1_exp  <= '0;
        end else if (en) begin
            n1_vld  <= s_al.vld;
            n1_sgn  <= s_al.sgn;
            n1_nan  <= s_al.nan;
            n1_inf  <= s_al.inf;
            n1_zero <= s_al.zero;
            n1_g    <= nrm_g;
            n1_s    <= nrm_s;
            n1_mant <= nrm_mant;
            n1_exp  <= nrm_exp;
        end
    end

    // ---------------- N2: round and pack ----------------
    logic        rnd_up, rnd_cy;
    logic [23:0] rnd_mant;
    logic [9:0]  rnd_exp;
    logic [31:0] pk_res;
    logic        pk_ovf, pk_unf, pk_inv;

    // RNE rounding, carry-out renormalization and special-case priority.
    always_comb begin
        rnd_up             = n1_g & (n1_s | n1_mant[0]);
        {rnd_cy, rnd_mant} = {1'b0, n1_mant} + {24'd0, rnd_up};
        rnd_exp            = n1_exp;
        if (rnd_cy) begin
            rnd_mant = 24'h800000;
            rnd_exp  = n1_exp + 10'd1;
        end
        pk_ovf = 1'b0;
        pk_unf = 1'b0;
        pk_inv = 1'b0;
        if (n1_nan) begin
            pk_res = 32'h7FC00000;
            pk_inv = 1'b1;
        end else if (n1_inf) begin
            pk_res = {n1_sgn, 8'hFF, 23'd0};
        end else if (n1_zero) begin
            pk_res = {n1_sgn, 31'd0};
        end else if ($signed(rnd_exp) >= 10'sd255) begin
            pk_res = {n1_sgn, 8'hFF, 23'd0};
            pk_ovf = 1'b1;
        end else if ($signed(rnd_exp) <= 10'sd0) begin
            pk_res = {n1_sgn, 31'd0};
            pk_unf = 1'b1;
        end else begin
            pk_res = {n1_sgn, rnd_exp[7:0], rnd_mant[22:0]};
        end
    end

    // Output register stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            invalid   <= 1'b0;
        end else if (en) begin
            out_valid <= n1_vld;
            result    <= pk_res;
            overflow  <= pk_ovf;
            underflow <= pk_unf;
            invalid   <= pk_inv;
        end
    end

endmodule

// File: tb/tb_fp32_mul_post.sv
// Bench for fp32_mul_post: behavioural 5-stage mantissa multiplier, a vector
// table of hand-computed products, and a scoreboard that checks each result,
// its flags and its enabled-edge latency.
module tb_fp32_mul_post;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        in_valid;
    logic [31:0] a, b;
    logic [23:0] man_a, man_b;
    logic [47:0] prod;
    logic        out_valid;
    logic [31:0] result;
    logic        overflow, underflow, invalid;

    fp32_mul_post #(.MULT_LAT(5), .EXP_BIAS(127)) dut (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .a(a), .b(b),
        .man_a(man_a), .man_b(man_b), .prod(prod), .out_valid(out_valid),
        .result(result), .overflow(overflow), .underflow(underflow),
        .invalid(invalid)
    );

    always #5 clk = ~clk;

    // Attached multiplier: same clk/en, active-low reset from ~rst.
    logic        mrst_n;
    logic [47:0] mpipe [5];
    assign mrst_n = ~rst;
    assign prod   = mpipe[4];
    always_ff @(posedge clk or negedge mrst_n) begin
        if (!mrst_n) begin
            for (int i = 0; i < 5; i++) mpipe[i] <= '0;
        end else if (en) begin
            mpipe[0] <= 48'(man_a) * 48'(man_b);
            for (int i = 1; i < 5; i++) mpipe[i] <= mpipe[i-1];
        end
    end

    typedef struct {
        logic [31:0] a, b, res;
        logic        ovf, unf, inv;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        ovf, unf, inv;
        int          stamp;
    } exp_t;

    vec_t vt [17];
    exp_t q [$];
    int   checks = 0;
    int   errors = 0;
    int   ecnt   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, want);
        end
    endtask

    // Issue one operation at the falling edge.
    task automatic op(input vec_t v);
        @(negedge clk);
        en = 1'b1; in_valid = 1'b1; a = v.a; b = v.b;
        q.push_back('{res: v.res, ovf: v.ovf, unf: v.unf, inv: v.inv, stamp: ecnt});
    endtask

    task automatic bubble();
        @(negedge clk);
        en = 1'b1; in_valid = 1'b0; a = $urandom; b = $urandom;
    endtask

    task automatic stall();
        @(negedge clk);
        en = 1'b0; in_valid = 1'b1; a = $urandom; b = $urandom;
    endtask

    // Monitor: pop on every enabled edge with out_valid; outputs must hold on stalls.
    logic        en_s, prev_v;
    logic [31:0] prev_r;
    exp_t        e;
    always @(posedge clk) begin
        en_s = en;
        #1;
        if (!rst) begin
            if (en_s) begin
                ecnt++;
                if (out_valid) begin
                    if (q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL stale_output got %h want none", result);
                    end else begin
                        e = q.pop_front();
                        chk("result_flags", {29'd0, result, overflow, underflow, invalid},
                            {29'd0, e.res, e.ovf, e.unf, e.inv});
                        chk("latency", 64'(ecnt - e.stamp), 64'd7);
                    end
                end
            end else begin
                chk("stall_hold", {31'd0, out_valid, result}, {31'd0, prev_v, prev_r});
            end
        end
        prev_v = out_valid;
        prev_r = result;
    end

    task automatic chk_zero_outputs(input string nm);
        chk({nm, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({nm, "_result"},    64'(result),    64'd0);
        chk({nm, "_overflow"},  64'(overflow),  64'd0);
        chk({nm, "_underflow"}, 64'(underflow), 64'd0);
        chk({nm, "_invalid"},   64'(invalid),   64'd0);
    endtask

    initial begin
        //         a             b             result        ovf   unf   inv
        vt[0]  = '{32'h3FC00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 1'b0};
        vt[1]  = '{32'hBF800000, 32'h40000000, 32'hC0000000, 1'b0, 1'b0, 1'b0};
        vt[2]  = '{32'h3F800001, 32'h3F800001, 32'h3F800002, 1'b0, 1'b0, 1'b0};
        vt[3]  = '{32'h7F000000, 32'h7F000000, 32'h7F800000, 1'b1, 1'b0, 1'b0};
        vt[4]  = '{32'h00800000, 32'h3F000000, 32'h00000000, 1'b0, 1'b1, 1'b0};
        vt[5]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 1'b0, 1'b0, 1'b1};
        vt[6]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 1'b0, 1'b0, 1'b0};
        vt[7]  = '{32'h00000001, 32'h3F800000, 32'h00000000, 1'b0, 1'b0, 1'b0};
        vt[8]  = '{32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 1'b0, 1'b0, 1'b0};
        vt[9]  = '{32'h3F800001, 32'h3FC00000, 32'h3FC00002, 1'b0, 1'b0, 1'b0};
        vt[10] = '{32'h3F800001, 32'h3FFFFFFE, 32'h40000000, 1'b0, 1'b0, 1'b0};
        vt[11] = '{32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF, 1'b0, 1'b0, 1'b0};
        vt[12] = '{32'h7F7FFFFF, 32'h3F800001, 32'h7F800000, 1'b1, 1'b0, 1'b0};
        vt[13] = '{32'h80800000, 32'h00800000, 32'h80000000, 1'b0, 1'b1, 1'b0};
        vt[14] = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b0, 1'b1};
        vt[15] = '{32'h80000000, 32'h40000000, 32'h80000000, 1'b0, 1'b0, 1'b0};
        vt[16] = '{32'hFF800000, 32'hFF800000, 32'h7F800000, 1'b0, 1'b0, 1'b0};

        rst = 1'b1; en = 1'b0; in_valid = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        chk_zero_outputs("reset");
        rst = 1'b0;

        // Back-to-back table, one bubble in the middle.
        for (int i = 0; i < 17; i++) begin
            op(vt[i]);
            if (i == 7) bubble();
        end
        repeat (10) bubble();

        // Stall for three cycles after the second issue.
        op(vt[0]);
        op(vt[9]);
        repeat (3) stall();
        op(vt[3]);
        op(vt[5]);
        repeat (10) bubble();

        // Async reset with operations in flight and a valid result showing.
        op(vt[12]);
        for (int i = 0; i < 7; i++) op(vt[i]);
        @(negedge clk);
        en = 1'b1; in_valid = 1'b0;
        #2 rst = 1'b1;
        #1 chk_zero_outputs("async_reset");
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (9) bubble();
        chk("post_reset_idle", 64'(out_valid), 64'd0);
        op(vt[10]);
        op(vt[1]);

        // Drain with a bounded wait.
        for (int i = 0; i < 40 && q.size() != 0; i++) bubble();
        if (q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
